// File: rtl/adder_monitor.sv
// adder_monitor: on-line checker comparing a registered signed adder's result against a delayed prediction.
module adder_monitor #(
  parameter int WIDTH         = 4,
  parameter int LATENCY       = 1,
  parameter int CNT_W         = 16,
  parameter bit STOP_ON_ERROR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dut_rst,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH:0]   C,
  output logic [CNT_W-1:0] correct_count,
  output logic [CNT_W-1:0] error_count,
  output logic             mismatch,
  output logic             fail,
  output logic [WIDTH:0]   err_expected,
  output logic [WIDTH:0]   err_actual,
  output logic             halted
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [WIDTH:0] exp_q [LATENCY];
  logic [WIDTH:0] push_e, eexp_q, eact_q;
  logic [CNT_W-1:0] cor_q, err_q;
  logic push_v, cmp, bad, mis_q, fail_q;
  always_comb begin
    push_v  = state_q != HALT && (dut_rst || en);
    push_e  = dut_rst ? '0 : {A[WIDTH-1], A} + {B[WIDTH-1], B};
    cmp     = state_q != HALT && vld_q[LATENCY-1];
    bad     = cmp && C != exp_q[LATENCY-1];
    state_d = state_q == IDLE ? (push_v ? RUN : IDLE) :
              state_q == RUN  ? ((bad && STOP_ON_ERROR) ? HALT : RUN) : HALT;
    // entering or sitting in HALT flushes every in-flight prediction
    vld_d   = state_d == HALT ? '0 : (vld_q << 1) | LATENCY'(push_v);
  end
  always_ff @(posedge clk) begin
    exp_q[0] <= push_e;
    for (int i = 1; i < LATENCY; i++) exp_q[i] <= exp_q[i-1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vld_q   <= '0;
      cor_q   <= '0;
      err_q   <= '0;
      mis_q   <= 1'b0;
      fail_q  <= 1'b0;
      eexp_q  <= '0;
      eact_q  <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      mis_q   <= bad;
      if (cmp && !bad && ~&cor_q) cor_q <= cor_q + CNT_W'(1);
      if (bad && ~&err_q) err_q <= err_q + CNT_W'(1);
      if (bad && !fail_q) begin
        fail_q <= 1'b1;
        eexp_q <= exp_q[LATENCY-1];
        eact_q <= C;
      end
    end
  end
  assign correct_count = cor_q;
  assign error_count   = err_q;
  assign mismatch      = mis_q;
  assign fail          = fail_q;
  assign err_expected  = eexp_q;
  assign err_actual    = eact_q;
  assign halted        = state_q == HALT;
endmodule

// File: tb/tb_adder_monitor.sv
// tb_adder_monitor: directed checks of adder_monitor across four parameterisations fed by a behavioural adder.
module tb_adder_monitor;
  logic clk = 1'b0, reset = 1'b0, dut_rst = 1'b0, en = 1'b0;
  logic [3:0] A = '0, B = '0;
  logic [4:0] s1 = '0, s2 = '0, s3 = '0, off0 = '0, off1 = '0;
  logic [4:0] C0, C1, C2, C3;
  logic [15:0] cc0, ec0, cc1, ec1, cc3, ec3;
  logic [3:0] cc2, ec2;
  logic m0, f0, h0, m1, f1, h1, m2, f2, h2, m3, f3, h3;
  logic [4:0] ee0, ea0, ee1, ea1, ee2, ea2, ee3, ea3;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  // behavioural registered adder with 1, 2 and 3 cycle taps
  always @(posedge clk) begin
    s1 <= dut_rst ? 5'd0 : {A[3], A} + {B[3], B};
    s2 <= s1;
    s3 <= s2;
  end
  assign C0 = s1 + off0;
  assign C1 = s3 + off1;
  assign C2 = s1;
  assign C3 = s2;
  adder_monitor u0 (.clk(clk), .reset(reset), .dut_rst(dut_rst), .en(en), .A(A), .B(B), .C(C0),
    .correct_count(cc0), .error_count(ec0), .mismatch(m0), .fail(f0),
    .err_expected(ee0), .err_actual(ea0), .halted(h0));
  adder_monitor #(.LATENCY(3), .STOP_ON_ERROR(1'b1)) u1 (.clk(clk), .reset(reset), .dut_rst(dut_rst),
    .en(en), .A(A), .B(B), .C(C1), .correct_count(cc1), .error_count(ec1), .mismatch(m1), .fail(f1),
    .err_expected(ee1), .err_actual(ea1), .halted(h1));
  adder_monitor #(.CNT_W(4)) u2 (.clk(clk), .reset(reset), .dut_rst(dut_rst), .en(en), .A(A), .B(B),
    .C(C2), .correct_count(cc2), .error_count(ec2), .mismatch(m2), .fail(f2),
    .err_expected(ee2), .err_actual(ea2), .halted(h2));
  adder_monitor #(.LATENCY(2)) u3 (.clk(clk), .reset(reset), .dut_rst(dut_rst), .en(en), .A(A), .B(B),
    .C(C3), .correct_count(cc3), .error_count(ec3), .mismatch(m3), .fail(f3),
    .err_expected(ee3), .err_actual(ea3), .halted(h3));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic e);
    A = a;
    B = b;
    en = e;
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step(4'd0, 4'd0, 1'b0);
    reset = 1'b0;
  endtask
  initial begin
    logic [3:0] va [9];
    logic [3:0] vb [9];
    va = '{4'h8, 4'h8, 4'h8, 4'h7, 4'h7, 4'h7, 4'h0, 4'h0, 4'h0};
    vb = '{4'h8, 4'h7, 4'h0, 4'h8, 4'h7, 4'h0, 4'h8, 4'h7, 4'h0};
    do_reset();
    chk("rst_cc", cc0, 0);
    chk("rst_ec", ec0, 0);
    chk("rst_mis", m0, 0);
    chk("rst_fail", f0, 0);
    chk("rst_eexp", ee0, 0);
    chk("rst_eact", ea0, 0);
    chk("rst_halt", h0, 0);
    // a dut_rst cycle predicts zero
    dut_rst = 1'b1;
    step(4'd0, 4'd0, 1'b0);
    dut_rst = 1'b0;
    chk("dutrst_lat", cc0, 0);
    step(4'd0, 4'd0, 1'b0);
    chk("dutrst_cc", cc0, 1);
    chk("dutrst_ec", ec0, 0);
    do_reset();
    for (int i = 0; i < 9; i++) step(va[i], vb[i], 1'b1);
    step(4'd0, 4'd0, 1'b0);
    chk("corner_cc", cc0, 9);
    chk("corner_ec", ec0, 0);
    chk("corner_fail", f0, 0);
    // C=13 where 7+7=14
    step(4'd7, 4'd7, 1'b1);
    off0 = 5'h1f;
    step(4'd0, 4'd0, 1'b0);
    off0 = '0;
    chk("inj_mis", m0, 1);
    chk("inj_ec", ec0, 1);
    chk("inj_fail", f0, 1);
    chk("inj_eexp", ee0, 14);
    chk("inj_eact", ea0, 13);
    chk("inj_cc", cc0, 9);
    chk("inj_halt", h0, 0);
    step(4'd0, 4'd0, 1'b0);
    chk("inj_mis_pulse", m0, 0);
    step(4'h8, 4'h8, 1'b1);
    off0 = 5'd1;
    step(4'd0, 4'd0, 1'b0);
    off0 = '0;
    chk("inj2_mis", m0, 1);
    chk("inj2_ec", ec0, 2);
    chk("inj2_eexp", ee0, 14);
    chk("inj2_eact", ea0, 13);
    // stop-on-error at latency 3: pushes 1+1,2+2 pass, 3+3 is corrupted
    do_reset();
    for (int i = 1; i <= 5; i++) step(4'(i), 4'(i), 1'b1);
    chk("stop_pre_cc", cc1, 2);
    off1 = 5'd1;
    step(4'd6, 4'd6, 1'b1);
    off1 = '0;
    chk("stop_halt", h1, 1);
    chk("stop_mis", m1, 1);
    chk("stop_ec", ec1, 1);
    chk("stop_cc", cc1, 2);
    chk("stop_eexp", ee1, 6);
    chk("stop_eact", ea1, 7);
    for (int i = 0; i < 5; i++) step(4'(i), 4'd1, 1'b1);
    chk("halt_hold", h1, 1);
    chk("halt_cc", cc1, 2);
    chk("halt_ec", ec1, 1);
    chk("halt_fail", f1, 1);
    do_reset();
    chk("halt_exit", h1, 0);
    // saturation with a 4-bit counter
    for (int i = 0; i < 20; i++) step(4'(i), 4'(3 * i), 1'b1);
    step(4'd0, 4'd0, 1'b0);
    chk("sat_cc", cc2, 15);
    chk("sat_ec", ec2, 0);
    // mid-run reset with two pushes in flight at latency 2
    do_reset();
    step(4'd1, 4'd1, 1'b1);
    step(4'd2, 4'd2, 1'b1);
    reset = 1'b1;
    step(4'd3, 4'd3, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(4'd0, 4'd0, 1'b0);
    chk("flush_cc", cc3, 0);
    chk("flush_ec", ec3, 0);
    step(4'd2, 4'd3, 1'b1);
    step(4'd0, 4'd0, 1'b0);
    chk("lat2_early", cc3, 0);
    step(4'd0, 4'd0, 1'b0);
    chk("lat2_cc", cc3, 1);
    chk("lat2_ec", ec3, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_monitor.md
# adder_monitor

Synthesizable on-line checker that sits on the output side of the registered signed `adder` and independently verifies every result it produces. It samples operands `A`/`B` and the DUT's own reset. It predicts the expected sum, delays the prediction by the DUT latency and compares it with the DUT output `C`. It keeps saturating pass/fail counters and captures the first failure, which gives silicon and emulation builds the self-checking the simulation bench provides.

## Interface
Parameters:
- `WIDTH`, 4: operand width; `C` is `WIDTH+1` bits.
- `LATENCY`, 1: DUT cycles from operand sample to valid `C`; legal range 1..4.
- `CNT_W`, 16: width of each counter.
- `STOP_ON_ERROR`, 0: when 1, the first mismatch halts checking.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high monitor reset.
- `dut_rst`, in, 1: copy of the reset driven into the adder.
- `en`, in, 1: `A`/`B` hold a valid operand pair this cycle.
- `A`, in, `WIDTH`: signed operand.
- `B`, in, `WIDTH`: signed operand.
- `C`, in, `WIDTH+1`: signed DUT result.
- `correct_count`, out, `CNT_W`: number of passing comparisons.
- `error_count`, out, `CNT_W`: number of failing comparisons.
- `mismatch`, out, 1: one-cycle pulse on each failing comparison.
- `fail`, out, 1: sticky; set by the first failure.
- `err_expected`, out, `WIDTH+1`: expected value at the first failure.
- `err_actual`, out, `WIDTH+1`: `C` at the first failure.
- `halted`, out, 1: high in state HALT.

## Operation
- Prediction at each edge:
  - If `dut_rst`=1, push {valid=1, exp=0}. Reset wins over `en`.
  - Else if `en`=1, push {valid=1, exp=sext(A)+sext(B)}, computed in `WIDTH+1` bits.
  - Else push {valid=0}.
- The prediction pipeline is `LATENCY` registers deep. The oldest entry is compared with `C` at the same edge.
- Expected range for `WIDTH`=4 is -16..14. The sum never overflows `WIDTH+1` bits, so there is no wrap handling.
- Compare on a valid entry:
  - `C`==exp: `correct_count`+1.
  - Otherwise: `error_count`+1, `mismatch`=1. If `fail`=0, set `fail` and capture `err_expected`/`err_actual`.
- Both counters saturate at 2^`CNT_W`-1 and then hold.
- State machine:
  - IDLE: after `reset`. Moves to RUN on the first valid push.
  - RUN: comparisons are active. Moves to HALT on a mismatch only when `STOP_ON_ERROR`=1.
  - HALT: no pushes and no comparisons. The pipeline is flushed to invalid and all outputs are frozen. Only `reset` exits HALT.
- In IDLE, comparisons of valid entries still occur. In practice none exist, because the first push moves the block to RUN.
- `reset` mid-operation:
  - All pipeline entries become invalid, so in-flight predictions are discarded.
  - Counters go to 0, `fail`/`mismatch`/`halted`/`err_*` go to 0, and the state goes to IDLE.
  - Inputs sampled on the reset edge are not pushed.

## Timing
- Reset values: `correct_count`=0, `error_count`=0, `mismatch`=0, `fail`=0, `err_expected`=0, `err_actual`=0, `halted`=0.
- A push sampled at edge t is compared at edge t+`LATENCY`. Counters, `mismatch` and `fail` are visible after that edge.
- `mismatch` is high for exactly one cycle per failure. Back-to-back failures keep it high on consecutive cycles.
- `halted` rises in the same cycle as the `mismatch` that causes the halt. That failure is still counted.
- No combinational paths from inputs to outputs; all outputs are registered.

## Test plan
- Reset check: hold `dut_rst`=1 for 1 cycle with `C`=0 (`LATENCY`=1) -> `correct_count`=1, `error_count`=0.
- Corner sums: apply A,B pairs (-8,-8), (-8,7), (-8,0), (7,-8), (7,7), (7,0), (0,-8), (0,7), (0,0) with a correct DUT -> expected values -16, -1, -8, -1, 14, 7, -8, 7, 0 all pass; `correct_count`=9, `fail`=0.
- Injected error: force `C`=13 for A=7, B=7 -> `mismatch` pulses at t+1, `error_count`=1, `fail`=1, `err_expected`=14, `err_actual`=13. A second error leaves `err_*` unchanged.
- `STOP_ON_ERROR`=1, `LATENCY`=3: inject an error, then 5 more valid pairs -> `halted`=1 and the counts freeze at their values after the error.
- Saturation, `CNT_W`=4: 20 passing comparisons -> `correct_count`=15.
- Mid-run `reset`: assert `reset` with 2 pushes in flight (`LATENCY`=2) -> all counts are 0 and no comparison occurs for the discarded entries.
